// File: rtl/input_cond_pkg.sv
// Shared types and counter-width helpers for the multi-channel input conditioner.
package input_cond_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_cond_ch.sv
// One conditioner channel: synchroniser chain, debounce filter, edge select and
// optional auto-repeat, with registered pulse and level outputs.
module input_cond_ch
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_in,
  input  edge_mode_t mode,
  output logic       pulse,
  output logic       level
);

  localparam int DB_W = cnt_width(DB_CYCLES);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic [DB_W-1:0]        db_cnt_r;
  logic [DB_W-1:0]        db_cnt_nxt_s;
  logic [DB_W-1:0]        db_inc_s;
  logic                   level_r;
  logic                   level_nxt_s;
  logic                   rise_s;
  logic                   fall_s;
  logic                   edge_hit_s;
  logic                   rpt_hit_s;
  logic                   pulse_r;

  assign sync_s   = sync_r[SYNC_STAGES-1];
  assign db_inc_s = db_cnt_r + DB_W'(1);
  assign rise_s   = level_nxt_s & ~level_r;
  assign fall_s   = ~level_nxt_s & level_r;

  // Synchroniser shift chain for the raw asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sw_in};
    end
  end

  // Debounce: accept a new level only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_nxt_s  = level_r;
    db_cnt_nxt_s = '0;
    if (sync_s != level_r) begin
      if (db_inc_s == DB_W'(DB_CYCLES)) begin
        level_nxt_s  = sync_s;
        db_cnt_nxt_s = '0;
      end else begin
        db_cnt_nxt_s = db_inc_s;
      end
    end else begin
      db_cnt_nxt_s = '0;
    end
  end

  // Edge selection by per-channel mode.
  always_comb begin
    edge_hit_s = 1'b0;
    case (mode)
      EDGE_NONE: edge_hit_s = 1'b0;
      EDGE_RISE: edge_hit_s = rise_s;
      EDGE_FALL: edge_hit_s = fall_s;
      EDGE_BOTH: edge_hit_s = rise_s | fall_s;
      default:   edge_hit_s = 1'b0;
    endcase
  end

  if (REPEAT_DELAY > 0) begin : g_rpt
    localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    logic [RW-1:0] rpt_cnt_r;
    logic [RW-1:0] rpt_cnt_nxt_s;
    logic [RW-1:0] rpt_inc_s;
    logic [RW-1:0] rpt_target_s;
    logic          rpt_first_r;
    logic          rpt_first_nxt_s;
    logic          rpt_fire_s;

    assign rpt_inc_s    = (rpt_cnt_r == {RW{1'b1}}) ? rpt_cnt_r : rpt_cnt_r + RW'(1);
    assign rpt_target_s = rpt_first_r ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);

    // Repeat timer: restarts on each rise, counts only while level stays high and
    // a falling edge this cycle suppresses the repeat so only the fall can fire.
    always_comb begin
      rpt_cnt_nxt_s   = '0;
      rpt_first_nxt_s = 1'b1;
      rpt_fire_s      = 1'b0;
      if (rise_s) begin
        rpt_cnt_nxt_s   = '0;
        rpt_first_nxt_s = 1'b1;
      end else if (level_r && level_nxt_s && mode[0]) begin
        if (rpt_inc_s == rpt_target_s) begin
          rpt_fire_s      = 1'b1;
          rpt_cnt_nxt_s   = '0;
          rpt_first_nxt_s = 1'b0;
        end else begin
          rpt_cnt_nxt_s   = rpt_inc_s;
          rpt_first_nxt_s = rpt_first_r;
        end
      end else begin
        rpt_cnt_nxt_s   = '0;
        rpt_first_nxt_s = 1'b1;
      end
    end

    // Repeat timer state.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rpt_cnt_r   <= '0;
        rpt_first_r <= 1'b1;
      end else begin
        rpt_cnt_r   <= rpt_cnt_nxt_s;
        rpt_first_r <= rpt_first_nxt_s;
      end
    end

    assign rpt_hit_s = rpt_fire_s;
  end else begin : g_no_rpt
    assign rpt_hit_s = 1'b0;
  end

  // Debounce counter, clean level and event strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_r <= '0;
      level_r  <= 1'b0;
      pulse_r  <= 1'b0;
    end else begin
      db_cnt_r <= db_cnt_nxt_s;
      level_r  <= level_nxt_s;
      pulse_r  <= edge_hit_s | rpt_hit_s;
    end
  end

  assign pulse = pulse_r;
  assign level = level_r;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel switch/button conditioner: N_CH independent channels, each with
// synchroniser, debounce, selectable edge events and optional auto-repeat.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   sw_in,
  input  logic [2*N_CH-1:0] mode,
  output logic [N_CH-1:0]   pulse,
  output logic [N_CH-1:0]   level
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    input_cond_ch #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .sw_in (sw_in[i]),
      .mode  (edge_mode_t'(mode[2*i +: 2])),
      .pulse (pulse[i]),
      .level (level[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner: three configurations
// (4-ch DB=4, 1-ch auto-repeat, 1-ch DB=1) driven from one clock and reset.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;

  logic [3:0] sw_a;
  logic [7:0] mode_a;
  logic [3:0] pulse_a;
  logic [3:0] level_a;

  logic [0:0] sw_b;
  logic [1:0] mode_b;
  logic [0:0] pulse_b;
  logic [0:0] level_b;

  logic [0:0] sw_c;
  logic [1:0] mode_c;
  logic [0:0] pulse_c;
  logic [0:0] level_c;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  input_conditioner #(.N_CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .REPEAT_DELAY(0),
                      .REPEAT_PERIOD(8)) dut_a (
    .clk(clk), .reset(reset), .sw_in(sw_a), .mode(mode_a), .pulse(pulse_a), .level(level_a));

  input_conditioner #(.N_CH(1), .SYNC_STAGES(2), .DB_CYCLES(4), .REPEAT_DELAY(10),
                      .REPEAT_PERIOD(4)) dut_b (
    .clk(clk), .reset(reset), .sw_in(sw_b), .mode(mode_b), .pulse(pulse_b), .level(level_b));

  input_conditioner #(.N_CH(1), .SYNC_STAGES(2), .DB_CYCLES(1), .REPEAT_DELAY(0),
                      .REPEAT_PERIOD(8)) dut_c (
    .clk(clk), .reset(reset), .sw_in(sw_c), .mode(mode_c), .pulse(pulse_c), .level(level_c));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int npulse;
    int nz;
    int p1;
    int p2;
    int ch1_pulses;

    reset  = 1'b1;
    sw_a   = 4'b0000;
    sw_b   = 1'b0;
    sw_c   = 1'b0;
    mode_a = 8'b01_01_00_01;   // ch3 RISE, ch2 RISE, ch1 NONE, ch0 RISE
    mode_b = 2'b01;
    mode_c = 2'b01;
    #12;
    check_val("rst_level_a", 32'(level_a), 32'h0);
    check_val("rst_pulse_a", 32'(pulse_a), 32'h0);
    check_val("rst_level_b", 32'(level_b), 32'h0);
    check_val("rst_level_c", 32'(level_c), 32'h0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Test 1: bounce every 2 cycles, then a clean rise.
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      sw_a[0] = ~sw_a[0];
      repeat (2) begin
        tick();
        npulse += int'(pulse_a[0]);
      end
    end
    check_val("t1_bounce_pulses", 32'(npulse), 32'd0);
    check_val("t1_bounce_level", 32'(level_a[0]), 32'd0);
    sw_a[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_val($sformatf("t1_pulse_e%0d", k), 32'(pulse_a[0]), 32'(k == 6));
      check_val($sformatf("t1_level_e%0d", k), 32'(level_a[0]), 32'(k >= 6));
    end

    // Test 2: BOTH mode, 20-cycle press on ch1.
    mode_a[3:2] = 2'b11;
    npulse = 0; p1 = -1; p2 = -1;
    sw_a[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (pulse_a[1]) begin
        npulse++;
        if (p1 < 0) p1 = k; else p2 = k;
      end
      if (k == 20) sw_a[1] = 1'b0;
    end
    check_val("t2_both_count", 32'(npulse), 32'd2);
    check_val("t2_both_rise_at", 32'(p1), 32'd6);
    check_val("t2_both_fall_at", 32'(p2), 32'd26);

    // Same press with NONE: level toggles, no pulses.
    mode_a[3:2] = 2'b00;
    npulse = 0;
    sw_a[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      npulse += int'(pulse_a[1]);
      if (k == 6)  check_val("t2_none_level_hi", 32'(level_a[1]), 32'd1);
      if (k == 26) check_val("t2_none_level_lo", 32'(level_a[1]), 32'd0);
      if (k == 20) sw_a[1] = 1'b0;
    end
    check_val("t2_none_count", 32'(npulse), 32'd0);

    // Test 5: ch0 and ch3 pressed together, ch1 bounces shorter than DB.
    sw_a = 4'b0000;
    repeat (10) tick();
    mode_a[3:2] = 2'b11;
    ch1_pulses = 0; nz = 0;
    sw_a = 4'b1011;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 3) sw_a[1] = 1'b0;
      ch1_pulses += int'(pulse_a[1]);
      if (pulse_a != 4'b0000) nz++;
      if (k == 6) check_val("t5_pulse_vec", 32'(pulse_a), 32'h9);
    end
    check_val("t5_ch1_pulses", 32'(ch1_pulses), 32'd0);
    check_val("t5_pulse_cycles", 32'(nz), 32'd1);
    check_val("t5_level_vec", 32'(level_a), 32'h9);

    // Test 4: reset mid-debounce on ch2 while ch0/ch3 are high.
    sw_a[2] = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check_val("t4_rst_level", 32'(level_a), 32'h0);
    check_val("t4_rst_pulse", 32'(pulse_a), 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_val($sformatf("t4_pulse_e%0d", k), 32'(pulse_a), (k == 6) ? 32'hd : 32'h0);
    end
    check_val("t4_level_after", 32'(level_a), 32'hd);

    // Test 3: auto-repeat, DELAY=10 PERIOD=4; rise at T=6, fall at T+30.
    sw_b = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 30) sw_b = 1'b0;
      check_val($sformatf("t3_pulse_c%0d", k), 32'(pulse_b),
                32'(k == 6 || k == 16 || k == 20 || k == 24 || k == 28 || k == 32));
      if (k == 35) check_val("t3_level_hi", 32'(level_b), 32'd1);
      if (k == 36) check_val("t3_level_lo", 32'(level_b), 32'd0);
    end

    // Test 6: DB=1 boundary; clean rise then a one-cycle glitch.
    sw_c = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_val($sformatf("t6_pulse_e%0d", k), 32'(pulse_c), 32'(k == 3));
      check_val($sformatf("t6_level_e%0d", k), 32'(level_c), 32'(k >= 3));
    end
    sw_c = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) sw_c = 1'b1;
      check_val($sformatf("t6_glitch_level_e%0d", k), 32'(level_c), 32'(k != 3));
      check_val($sformatf("t6_glitch_pulse_e%0d", k), 32'(pulse_c), 32'(k == 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
